// File: rtl/scrambler_pkg.sv
// Shared constants and types for the x^58 + x^39 + 1 TX scrambler.
package scrambler_pkg;

  localparam int POLY_WIDTH = 58;
  localparam int TAP_HI     = 57;
  localparam int TAP_LO     = 38;

  typedef logic [POLY_WIDTH-1:0] lfsr_t;

  localparam lfsr_t SEED_RESET = '1;

endpackage

// File: rtl/scrambler_step.sv
// Combinational one-word step of the self-synchronous scrambler.
// Bit DATA_WIDTH-1 is first on the line and enters the LFSR first.
module scrambler_step
  import scrambler_pkg::*;
#(
  parameter int DATA_WIDTH = 62
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [POLY_WIDTH-1:0] state_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [POLY_WIDTH-1:0] state_out
);

  lfsr_t st;
  logic  s;

  // Each scrambled bit is fed back, so the register tracks the line stream.
  always_comb begin
    st       = state_in;
    s        = 1'b0;
    data_out = '0;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      s                       = data_in[DATA_WIDTH-1-k] ^ st[TAP_LO] ^ st[TAP_HI];
      data_out[DATA_WIDTH-1-k] = s;
      st                      = {st[POLY_WIDTH-2:0], s};
    end
    state_out = st;
  end

endmodule

// File: rtl/scrambler.sv
// TX scrambler with valid/ready handshake, bypass and runtime reseed.
// Optional beat counter enabled by defining SCRAMBLER_BEAT_CNT_EN.
module scrambler
  import scrambler_pkg::*;
#(
  parameter int DATA_WIDTH = 62
) (
  input  logic                  clk_390p625M,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  input  logic                  scrambler_en,
  input  logic                  seed_load,
  input  logic [POLY_WIDTH-1:0] seed_value,
  output logic [DATA_WIDTH-1:0] scrambled_data_out,
  output logic                  scrambled_data_out_valid,
  input  logic                  scrambled_data_out_ready
`ifdef SCRAMBLER_BEAT_CNT_EN
  ,
  output logic [31:0]           beat_cnt
`endif
);

  lfsr_t                 lfsr;
  lfsr_t                 lfsr_next;
  logic [DATA_WIDTH-1:0] scrambled;
  logic                  accept;

  scrambler_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .data_in  (data_in),
    .state_in (lfsr),
    .data_out (scrambled),
    .state_out(lfsr_next)
  );

  // Held low during reset so nothing is accepted into a register being cleared.
  assign data_in_ready = !rst && (!scrambled_data_out_valid || scrambled_data_out_ready);
  assign accept        = data_in_valid && data_in_ready;

  always_ff @(posedge clk_390p625M) begin
    if (rst) begin
      scrambled_data_out       <= '0;
      scrambled_data_out_valid <= 1'b0;
    end else if (accept) begin
      scrambled_data_out       <= scrambler_en ? scrambled : data_in;
      scrambled_data_out_valid <= 1'b1;
    end else if (scrambled_data_out_ready) begin
      scrambled_data_out_valid <= 1'b0;
    end
  end

  // A reseed wins over the step, but the beat in that cycle already used the old state.
  always_ff @(posedge clk_390p625M) begin
    if (rst) begin
      lfsr <= SEED_RESET;
    end else if (seed_load) begin
      lfsr <= seed_value;
    end else if (accept && scrambler_en) begin
      lfsr <= lfsr_next;
    end
  end

`ifdef SCRAMBLER_BEAT_CNT_EN
  always_ff @(posedge clk_390p625M) begin
    if (rst || seed_load) begin
      beat_cnt <= '0;
    end else if (accept && scrambler_en && (beat_cnt != 32'hFFFF_FFFF)) begin
      beat_cnt <= beat_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_scrambler.sv
// Scoreboard bench for scrambler: driver pushes expected beats, monitor pops on output handshakes.
`timescale 1ns/1ps
module tb_scrambler;
  import scrambler_pkg::*;

  localparam int DW = 62;
  localparam logic [DW-1:0] ZERO_SEED_OUT = 62'h0000_0000_007F_FFF0;

  typedef struct {
    logic [DW-1:0] exp;
    logic [DW-1:0] din;
    logic          en;
    logic          loop_chk;
  } sb_t;

  logic          clk_390p625M = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          data_in_valid = 1'b0;
  logic          data_in_ready;
  logic          scrambler_en = 1'b1;
  logic          seed_load = 1'b0;
  lfsr_t         seed_value = '0;
  logic [DW-1:0] scrambled_data_out;
  logic          scrambled_data_out_valid;
  logic          scrambled_data_out_ready = 1'b1;
`ifdef SCRAMBLER_BEAT_CNT_EN
  logic [31:0]   beat_cnt;
`endif

  scrambler #(.DATA_WIDTH(DW)) dut (
    .clk_390p625M            (clk_390p625M),
    .rst                     (rst),
    .data_in                 (data_in),
    .data_in_valid           (data_in_valid),
    .data_in_ready           (data_in_ready),
    .scrambler_en            (scrambler_en),
    .seed_load               (seed_load),
    .seed_value              (seed_value),
    .scrambled_data_out      (scrambled_data_out),
    .scrambled_data_out_valid(scrambled_data_out_valid),
    .scrambled_data_out_ready(scrambled_data_out_ready)
`ifdef SCRAMBLER_BEAT_CNT_EN
    ,
    .beat_cnt                (beat_cnt)
`endif
  );

  always #5 clk_390p625M = ~clk_390p625M;

  int            n_cmp = 0;
  int            n_fail = 0;
  sb_t           exp_q[$];
  lfsr_t         model_lfsr = '1;
  logic [31:0]   model_cnt = '0;
  lfsr_t         desc_state = '1;
  sb_t           mon_e;
  logic [DW-1:0] mon_rec;
  lfsr_t         mon_nst;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Serial reference: taps at x^39/x^58 read as bits 38/57, line-order MSB first.
  function automatic logic [DW-1:0] ref_scramble(input logic [DW-1:0] d, input lfsr_t st_in,
                                                 output lfsr_t st_out);
    lfsr_t         st;
    logic [DW-1:0] w;
    logic          b;
    st = st_in;
    w  = '0;
    for (int k = 0; k < DW; k++) begin
      b = d[DW-1-k] ^ st[38] ^ st[57];
      w[DW-1-k] = b;
      st = {st[56:0], b};
    end
    st_out = st;
    return w;
  endfunction

  function automatic logic [DW-1:0] ref_descramble(input logic [DW-1:0] s, input lfsr_t st_in,
                                                   output lfsr_t st_out);
    lfsr_t         st;
    logic [DW-1:0] w;
    st = st_in;
    w  = '0;
    for (int k = 0; k < DW; k++) begin
      w[DW-1-k] = s[DW-1-k] ^ st[38] ^ st[57];
      st = {st[56:0], s[DW-1-k]};
    end
    st_out = st;
    return w;
  endfunction

  function automatic logic [DW-1:0] pattern(input int i);
    logic [63:0] t;
    t = {32'(i) * 32'h9E37_79B9, ~(32'(i) * 32'h85EB_CA6B)};
    return t[DW-1:0];
  endfunction

  task automatic apply_stimulus(input logic [DW-1:0] d, input logic en, input logic sl,
                                input lfsr_t sv, input logic use_const,
                                input logic [DW-1:0] const_exp, input logic loop_chk,
                                output int waited);
    sb_t           e;
    lfsr_t         nxt;
    logic [DW-1:0] w;
    data_in       = d;
    data_in_valid = 1'b1;
    scrambler_en  = en;
    seed_load     = sl;
    seed_value    = sv;
    waited        = 0;
    @(negedge clk_390p625M);
    while (!data_in_ready && waited < 50) begin
      waited++;
      @(negedge clk_390p625M);
    end
    if (!data_in_ready) begin
      check_output("accept_timeout", 64'd0, 64'd1);
    end else begin
      w          = ref_scramble(d, model_lfsr, nxt);
      e.exp      = en ? (use_const ? const_exp : w) : d;
      e.din      = d;
      e.en       = en;
      e.loop_chk = loop_chk;
      exp_q.push_back(e);
      if (sl) model_lfsr = sv;
      else if (en) model_lfsr = nxt;
      if (sl) model_cnt = '0;
      else if (en && model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 32'd1;
    end
    @(posedge clk_390p625M);
    #1;
    data_in_valid = 1'b0;
    seed_load     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk_390p625M);
    @(negedge clk_390p625M);
    check_output("rst_ready", 64'(data_in_ready), 64'd0);
    check_output("rst_valid", 64'(scrambled_data_out_valid), 64'd0);
    check_output("rst_data", 64'(scrambled_data_out), 64'd0);
`ifdef SCRAMBLER_BEAT_CNT_EN
    check_output("rst_beat_cnt", 64'(beat_cnt), 64'd0);
`endif
    exp_q.delete();
    model_lfsr = '1;
    model_cnt  = '0;
    @(posedge clk_390p625M);
    #1;
    rst = 1'b0;
    @(negedge clk_390p625M);
    check_output("post_rst_ready", 64'(data_in_ready), 64'd1);
    @(posedge clk_390p625M);
    #1;
  endtask

  task automatic drain();
    scrambled_data_out_ready = 1'b1;
    repeat (3) @(posedge clk_390p625M);
    #1;
  endtask

  task automatic check_cnt(input string name, input logic [31:0] exp);
`ifdef SCRAMBLER_BEAT_CNT_EN
    check_output(name, 64'(beat_cnt), 64'(exp));
`endif
  endtask

  // Monitor: a beat leaves the DUT when valid and ready are both high at the coming edge.
  always @(negedge clk_390p625M) begin
    if (rst) begin
      desc_state = '1;
    end else if (scrambled_data_out_valid && scrambled_data_out_ready) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_beat", 64'(scrambled_data_out), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("beat_data", 64'(scrambled_data_out), 64'(mon_e.exp));
        if (mon_e.en) begin
          mon_rec    = ref_descramble(scrambled_data_out, desc_state, mon_nst);
          desc_state = mon_nst;
          if (mon_e.loop_chk) check_output("loopback", 64'(mon_rec), 64'(mon_e.din));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int            waited;
    logic [DW-1:0] held;

    // Single zero beat from the all-ones seed, then one-cycle latency.
    do_reset();
    scrambled_data_out_ready = 1'b1;
    apply_stimulus('0, 1'b1, 1'b0, '0, 1'b1, ZERO_SEED_OUT, 1'b0, waited);
    check_output("latency_valid", 64'(scrambled_data_out_valid), 64'd1);
    drain();

    // Back-to-back beats with loopback through the reference descrambler.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(pattern(i), 1'b1, 1'b0, '0, 1'b0, '0, (i >= 1), waited);
      check_output("throughput", 64'(waited), 64'd0);
    end
    check_cnt("cnt_b2b", 32'd40);
    drain();

    // Backpressure: output held, next beat refused, LFSR must not advance.
    scrambled_data_out_ready = 1'b0;
    apply_stimulus(pattern(100), 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, waited);
    held          = exp_q[$].exp;
    data_in       = pattern(101);
    data_in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_390p625M);
      check_output("bp_ready", 64'(data_in_ready), 64'd0);
      check_output("bp_hold", 64'(scrambled_data_out), 64'(held));
    end
    @(posedge clk_390p625M);
    #1;
    data_in_valid            = 1'b0;
    scrambled_data_out_ready = 1'b1;
    apply_stimulus(pattern(101), 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, waited);
    drain();

    // Bypass on the third of six beats.
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(pattern(200 + i), (i != 2), 1'b0, '0, 1'b0, '0, 1'b0, waited);
    end
    check_cnt("cnt_bypass", 32'd47);
    drain();

    // Reseed to all ones alongside a beat; the following zero beat restarts the sequence.
    apply_stimulus(pattern(300), 1'b1, 1'b1, '1, 1'b0, '0, 1'b0, waited);
    apply_stimulus('0, 1'b1, 1'b0, '0, 1'b1, ZERO_SEED_OUT, 1'b0, waited);
    check_cnt("cnt_seed", 32'd1);
    drain();

    // Reset with a stalled beat pending: it is dropped and the seed returns to all ones.
    scrambled_data_out_ready = 1'b0;
    apply_stimulus(pattern(400), 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, waited);
    do_reset();
    scrambled_data_out_ready = 1'b1;
    apply_stimulus('0, 1'b1, 1'b0, '0, 1'b1, ZERO_SEED_OUT, 1'b0, waited);
    drain();

    check_output("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
